// File: rtl/fifo_mc_pkg.sv
// rtl/fifo_mc_pkg.sv - shared types and helpers for the multi-channel FIFO
package fifo_mc_pkg;

  localparam int CH_IDX_W = 8;

  // Wide channel index, used when comparing a request against NUM_CH.
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // The channel selects a 2**awidth region; the pointer selects the slot inside it.
  function automatic logic [31:0] ram_addr(input logic [31:0] ch, input logic [31:0] ptr,
                                           input int awidth);
    return (ch << awidth) | ptr;
  endfunction

endpackage

// File: rtl/fifo_mc_ram.sv
// rtl/fifo_mc_ram.sv - simple dual-port RAM shared by all channel regions
module fifo_mc_ram #(
  parameter int DWIDTH = 32,
  parameter int AW     = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_mc.sv
// rtl/fifo_mc.sv - multi-channel synchronous FIFO over one partitioned dual-port RAM
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter int DWIDTH             = 32,
  parameter int AWIDTH             = 4,
  parameter int NUM_CH             = 4,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 4,
  parameter int REGISTER_OUTPUT    = 0,
  localparam int CH_W              = calc_ch_w(NUM_CH)
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [DWIDTH-1:0]             data_i,
  input  logic                          wrreq_i,
  input  logic [CH_W-1:0]               wr_ch_i,
  input  logic                          rdreq_i,
  input  logic [CH_W-1:0]               rd_ch_i,
  output logic [DWIDTH-1:0]             q_o,
  output logic                          q_valid_o,
  output logic [CH_W-1:0]               q_ch_o,
  output logic [NUM_CH-1:0]             empty_o,
  output logic [NUM_CH-1:0]             full_o,
  output logic [NUM_CH-1:0][AWIDTH:0]   usedw_o,
  output logic [NUM_CH-1:0]             almost_full_o,
  output logic [NUM_CH-1:0]             almost_empty_o,
  output logic                          ovf_o,
  output logic                          udf_o
);

  localparam int RA_W = CH_W + AWIDTH;
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(2**AWIDTH);

  logic [AWIDTH:0]   usedw  [NUM_CH];
  logic [AWIDTH-1:0] wr_ptr [NUM_CH];
  logic [AWIDTH-1:0] rd_ptr [NUM_CH];
  logic [NUM_CH-1:0] wr_hit, rd_hit;
  logic              wr_ok, rd_ok;
  logic [RA_W-1:0]   wr_addr, rd_addr;
  logic [DWIDTH-1:0] ram_q;
  logic              rd_v1;
  logic [CH_W-1:0]   rd_ch1;
  logic              q_seen;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      usedw_o[c]        = usedw[c];
      empty_o[c]        = (usedw[c] == '0);
      full_o[c]         = (usedw[c] == DEPTH);
      almost_full_o[c]  = (32'(usedw[c]) >= 32'(ALMOST_FULL_VALUE));
      almost_empty_o[c] = (32'(usedw[c]) < 32'(ALMOST_EMPTY_VALUE));
    end
  end

  // Flags come from this cycle's registered usedw, so a full channel rejects
  // a write even when the same cycle reads from it.
  always_comb begin
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    if (wrreq_i && (ch_idx_t'(wr_ch_i) < ch_idx_t'(NUM_CH))) wr_ok = !full_o[wr_ch_i];
    if (rdreq_i && (ch_idx_t'(rd_ch_i) < ch_idx_t'(NUM_CH))) rd_ok = !empty_o[rd_ch_i];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = wr_ok && (wr_ch_i == CH_W'(c));
      rd_hit[c] = rd_ok && (rd_ch_i == CH_W'(c));
    end
  end

  assign wr_addr = RA_W'(ram_addr(32'(wr_ch_i), 32'(wr_ptr[wr_ch_i]), AWIDTH));
  assign rd_addr = RA_W'(ram_addr(32'(rd_ch_i), 32'(rd_ptr[rd_ch_i]), AWIDTH));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        usedw[c]  <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      rd_v1  <= 1'b0;
      rd_ch1 <= '0;
      q_seen <= 1'b0;
      ovf_o  <= 1'b0;
      udf_o  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_hit[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (rd_hit[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({wr_hit[c], rd_hit[c]})
          2'b10:   usedw[c] <= usedw[c] + 1'b1;
          2'b01:   usedw[c] <= usedw[c] - 1'b1;
          default: usedw[c] <= usedw[c];
        endcase
      end
      rd_v1 <= rd_ok;
      if (rd_ok) begin
        rd_ch1 <= rd_ch_i;
        q_seen <= 1'b1;
      end
      ovf_o <= wrreq_i && !wr_ok;
      udf_o <= rdreq_i && !rd_ok;
    end
  end

  fifo_mc_ram #(
    .DWIDTH (DWIDTH),
    .AW     (RA_W),
    .DEPTH  (NUM_CH * (2**AWIDTH))
  ) u_ram (
    .clk_i (clk_i),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (data_i),
    .re    (rd_ok),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  generate
    if (REGISTER_OUTPUT != 0) begin : g_oreg
      always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
          q_o       <= '0;
          q_valid_o <= 1'b0;
          q_ch_o    <= '0;
        end else begin
          q_valid_o <= rd_v1;
          if (rd_v1) begin
            q_o    <= ram_q;
            q_ch_o <= rd_ch1;
          end
        end
      end
    end else begin : g_noreg
      // RAM output is unreset; mask it until the first read after reset lands.
      assign q_o       = q_seen ? ram_q : '0;
      assign q_valid_o = rd_v1;
      assign q_ch_o    = rd_ch1;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_mc.sv
// tb/tb_fifo_mc.sv - scoreboard bench for the multi-channel FIFO
module tb_fifo_mc;

  localparam int DW = 32, AW = 4, NCH = 4, REG_OUT = 0, DEPTH = 16;

  logic clk = 1'b0, arstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] data = '0;
  logic wrreq = 1'b0, rdreq = 1'b0;
  logic [1:0] wr_ch = '0, rd_ch = '0;
  logic [DW-1:0] q;
  logic q_valid, ovf, udf;
  logic [1:0] q_ch;
  logic [NCH-1:0] empty, full, afull, aempty;
  logic [NCH-1:0][AW:0] usedw;

  logic [DW-1:0] d3 = '0;
  logic w3 = 1'b0, r3 = 1'b0;
  logic [1:0] wch3 = '0, rch3 = '0;
  logic [DW-1:0] q3;
  logic qv3, ovf3, udf3;
  logic [1:0] qch3;
  logic [2:0] empty3, full3, af3, ae3;
  logic [2:0][AW:0] usedw3;

  fifo_mc #(.DWIDTH(DW), .AWIDTH(AW), .NUM_CH(NCH), .ALMOST_FULL_VALUE(12),
            .ALMOST_EMPTY_VALUE(4), .REGISTER_OUTPUT(REG_OUT)) u_dut (
    .clk_i(clk), .arstn_i(arstn), .data_i(data), .wrreq_i(wrreq), .wr_ch_i(wr_ch),
    .rdreq_i(rdreq), .rd_ch_i(rd_ch), .q_o(q), .q_valid_o(q_valid), .q_ch_o(q_ch),
    .empty_o(empty), .full_o(full), .usedw_o(usedw), .almost_full_o(afull),
    .almost_empty_o(aempty), .ovf_o(ovf), .udf_o(udf));

  fifo_mc #(.DWIDTH(DW), .AWIDTH(AW), .NUM_CH(3), .ALMOST_FULL_VALUE(12),
            .ALMOST_EMPTY_VALUE(4), .REGISTER_OUTPUT(1)) u_dut3 (
    .clk_i(clk), .arstn_i(arstn), .data_i(d3), .wrreq_i(w3), .wr_ch_i(wch3),
    .rdreq_i(r3), .rd_ch_i(rch3), .q_o(q3), .q_valid_o(qv3), .q_ch_o(qch3),
    .empty_o(empty3), .full_o(full3), .usedw_o(usedw3), .almost_full_o(af3),
    .almost_empty_o(ae3), .ovf_o(ovf3), .udf_o(udf3));

  int n_checks = 0, n_pass = 0, cyc = 0;
  logic [DW-1:0] m_q [NCH][$];
  logic [33:0] sb_q[$];
  int sb_cyc[$];
  logic exp_ovf = 1'b0, exp_udf = 1'b0;
  logic [33:0] e;
  int ec;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arstn) begin
      n_checks++;
      if (ovf !== exp_ovf) $display("FAIL ovf_pulse t=%0t got %b exp %b", $time, ovf, exp_ovf);
      else n_pass++;
      n_checks++;
      if (udf !== exp_udf) $display("FAIL udf_pulse t=%0t got %b exp %b", $time, udf, exp_udf);
      else n_pass++;
      if (q_valid === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL spurious_q_valid t=%0t got q=%h exp no output", $time, q);
        else begin
          e = sb_q.pop_front();
          ec = sb_cyc.pop_front();
          if (q !== e[31:0] || q_ch !== e[33:32] || cyc !== ec)
            $display("FAIL read_data got q=%h ch=%0d cyc=%0d exp q=%h ch=%0d cyc=%0d",
                     q, q_ch, cyc, e[31:0], e[33:32], ec);
          else n_pass++;
        end
      end
    end
  end

  task automatic cycle(input bit wr, input logic [1:0] wch, input logic [31:0] d,
                       input bit rd, input logic [1:0] rch);
    bit wa, ra;
    wrreq = wr; wr_ch = wch; data = d; rdreq = rd; rd_ch = rch;
    wa = wr && (m_q[wch].size() < DEPTH);
    ra = rd && (m_q[rch].size() > 0);
    if (ra) begin
      sb_q.push_back({rch, m_q[rch].pop_front()});
      sb_cyc.push_back(cyc + 1 + REG_OUT);
    end
    if (wa) m_q[wch].push_back(d);
    @(posedge clk);
    exp_ovf = wr && !wa;
    exp_udf = rd && !ra;
    #1;
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (empty !== 4'hF || full !== 4'h0) $display("FAIL reset_flags got empty=%b full=%b exp 1111/0000", empty, full);
    else n_pass++;
    n_checks++;
    if (usedw !== '0) $display("FAIL reset_usedw got %h exp 0", usedw);
    else n_pass++;
    n_checks++;
    if (aempty !== 4'hF || afull !== 4'h0) $display("FAIL reset_almost got ae=%b af=%b exp 1111/0000", aempty, afull);
    else n_pass++;
    n_checks++;
    if (q_valid !== 1'b0 || q !== '0 || q_ch !== '0) $display("FAIL reset_q got v=%b q=%h ch=%0d exp 0", q_valid, q, q_ch);
    else n_pass++;
  endtask

  task automatic test_fill_ch2();
    for (int i = 0; i < 16; i++) begin
      cycle(1, 2, i, 0, 0);
      n_checks++;
      if (usedw[2] !== 5'(i + 1) || afull[2] !== (i + 1 >= 12) || aempty[2] !== (i + 1 < 4))
        $display("FAIL fill_level i=%0d got used=%0d af=%b ae=%b", i, usedw[2], afull[2], aempty[2]);
      else n_pass++;
    end
    cycle(1, 2, 32'hDEAD, 0, 0);
    n_checks++;
    if (ovf !== 1'b1 || full !== 4'b0100 || empty !== 4'b1011)
      $display("FAIL fill_full got ovf=%b full=%b empty=%b exp 1/0100/1011", ovf, full, empty);
    else n_pass++;
    n_checks++;
    if (usedw !== {5'd0, 5'd16, 5'd0, 5'd0}) $display("FAIL fill_usedw got %h exp 16 on ch2 only", usedw);
    else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_single got %b exp 0", ovf);
    else n_pass++;
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (empty !== 4'hF) $display("FAIL drain_ch2 got empty=%b exp 1111", empty);
    else n_pass++;
  endtask

  task automatic test_interleave();
    cycle(1, 0, 32'hA0, 0, 0);
    cycle(1, 3, 32'hB0, 0, 0);
    cycle(1, 0, 32'hA1, 0, 0);
    cycle(1, 3, 32'hB1, 0, 0);
    cycle(0, 0, 0, 1, 3);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 32'hA2, 1, 3);
    n_checks++;
    if (usedw[0] !== 5'd2 || usedw[3] !== 5'd0) $display("FAIL cross_channel got u0=%0d u3=%0d exp 2/0", usedw[0], usedw[3]);
    else n_pass++;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) cycle(1, 1, 32'h100 + i, 0, 0);
    cycle(1, 1, 32'hBAD1, 1, 1);
    n_checks++;
    if (ovf !== 1'b1 || usedw[1] !== 5'd15) $display("FAIL full_rw got ovf=%b used=%0d exp 1/15", ovf, usedw[1]);
    else n_pass++;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1);
    cycle(1, 1, 32'h200, 1, 1);
    n_checks++;
    if (usedw[1] !== 5'd5) $display("FAIL mid_rw got used=%0d exp 5", usedw[1]);
    else n_pass++;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);
    cycle(1, 1, 32'h300, 1, 1);
    n_checks++;
    if (udf !== 1'b1 || usedw[1] !== 5'd1) $display("FAIL empty_rw got udf=%b used=%0d exp 1/1", udf, usedw[1]);
    else n_pass++;
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_underflow();
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (udf !== 1'b1 || q_valid !== 1'b0) $display("FAIL underflow got udf=%b qv=%b exp 1/0", udf, q_valid);
    else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (udf !== 1'b0 || q_valid !== 1'b0) $display("FAIL underflow_after got udf=%b qv=%b exp 0/0", udf, q_valid);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    w3 = 1'b1; wch3 = 2'd3; d3 = 32'h1234; r3 = 1'b1; rch3 = 2'd3;
    cycle(0, 0, 0, 0, 0);
    w3 = 1'b0; r3 = 1'b0;
    n_checks++;
    if (ovf3 !== 1'b1 || udf3 !== 1'b1 || qv3 !== 1'b0)
      $display("FAIL oor_pulse got ovf=%b udf=%b qv=%b exp 1/1/0", ovf3, udf3, qv3);
    else n_pass++;
    n_checks++;
    if (usedw3 !== '0 || empty3 !== 3'b111) $display("FAIL oor_state got used=%h empty=%b exp 0/111", usedw3, empty3);
    else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (ovf3 !== 1'b0 || udf3 !== 1'b0) $display("FAIL oor_single got ovf=%b udf=%b exp 0/0", ovf3, udf3);
    else n_pass++;
    w3 = 1'b1; wch3 = 2'd2; d3 = 32'hCAFE0003;
    cycle(0, 0, 0, 0, 0);
    w3 = 1'b0;
    n_checks++;
    if (empty3 !== 3'b011 || usedw3[2] !== 5'd1) $display("FAIL nc3_write got empty=%b used=%0d exp 011/1", empty3, usedw3[2]);
    else n_pass++;
    r3 = 1'b1; rch3 = 2'd2;
    cycle(0, 0, 0, 0, 0);
    r3 = 1'b0;
    n_checks++;
    if (qv3 !== 1'b0) $display("FAIL reg_latency_early got qv=%b exp 0", qv3);
    else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (qv3 !== 1'b1 || q3 !== 32'hCAFE0003 || qch3 !== 2'd2)
      $display("FAIL reg_latency got qv=%b q=%h ch=%0d exp 1/cafe0003/2", qv3, q3, qch3);
    else n_pass++;
    cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (qv3 !== 1'b0 || q3 !== 32'hCAFE0003 || empty3 !== 3'b111)
      $display("FAIL reg_hold got qv=%b q=%h empty=%b exp 0/cafe0003/111", qv3, q3, empty3);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 32'h700 + i, 0, 0);
    cycle(0, 0, 0, 1, 1);
    n_checks++;
    if (usedw[1] !== 5'd7 || q_valid !== 1'b1) $display("FAIL pre_reset got used=%0d qv=%b exp 7/1", usedw[1], q_valid);
    else n_pass++;
    rdreq = 1'b1; rd_ch = 2'd1;
    #3 arstn = 1'b0;
    #1;
    n_checks++;
    if (q_valid !== 1'b0 || q !== '0 || usedw !== '0 || empty !== 4'hF)
      $display("FAIL async_clear got qv=%b q=%h used=%h empty=%b", q_valid, q, usedw, empty);
    else n_pass++;
    rdreq = 1'b0;
    sb_q.delete(); sb_cyc.delete();
    for (int c = 0; c < NCH; c++) m_q[c].delete();
    exp_ovf = 1'b0; exp_udf = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 arstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (q_valid !== 1'b0 || usedw[1] !== 5'd0) $display("FAIL post_reset got qv=%b used=%0d exp 0/0", q_valid, usedw[1]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(1, 2)), $urandom,
            $urandom_range(0, 4) > 1, 2'($urandom_range(1, 2)));
    for (int c = 0; c < NCH; c++)
      while (m_q[c].size() > 0) cycle(0, 0, 0, 1, 2'(c));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (empty !== 4'hF) $display("FAIL wrap_drain got empty=%b exp 1111", empty);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 arstn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill_ch2();
    test_interleave();
    test_full_rw();
    test_underflow();
    test_out_of_range();
    test_async_reset();
    test_wrap();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL missing_reads got %0d outstanding exp 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
